// File: rtl/bsg_counter_up_down_multi.sv
// Bank of independent up/down counters with a shared parameter set.
// Each channel saturates or wraps on over/underflow and keeps sticky error flags.
module bsg_counter_up_down_multi #(
    parameter int unsigned els_p      = 4,
    parameter int unsigned max_val_p  = 255,
    parameter int unsigned init_val_p = 0,
    parameter int unsigned max_step_p = 1,
    parameter int unsigned saturate_p = 1,
    localparam int unsigned step_width_lp = $clog2(max_step_p + 1),
    localparam int unsigned ptr_width_lp  = $clog2(max_val_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [els_p*step_width_lp-1:0]  up_i,
    input  logic [els_p*step_width_lp-1:0]  down_i,
    input  logic [els_p-1:0]                load_v_i,
    input  logic [els_p*ptr_width_lp-1:0]   load_val_i,
    input  logic                            err_clear_i,
    output logic [els_p*ptr_width_lp-1:0]   count_o,
    output logic [els_p-1:0]                zero_o,
    output logic [els_p-1:0]                full_o,
    output logic [els_p-1:0]                overflow_o,
    output logic [els_p-1:0]                underflow_o
);

    // Two extra bits hold count - down + up with sign and carry, no truncation.
    localparam int unsigned SumWidth = ptr_width_lp + 2;
    typedef logic signed [SumWidth-1:0] sum_t;

    localparam sum_t                     MaxSum  = sum_t'(max_val_p);
    localparam logic [ptr_width_lp-1:0] MaxVal  = ptr_width_lp'(max_val_p);
    localparam logic [ptr_width_lp-1:0] InitVal = ptr_width_lp'(init_val_p);
    // Modulus truncated to the count width; wrap results only need the low bits.
    localparam logic [ptr_width_lp-1:0] ModLow  = ptr_width_lp'(max_val_p + 1);

    if (init_val_p > max_val_p || max_step_p < 1 || max_step_p > max_val_p) begin : g_param_err
        $error("bsg_counter_up_down_multi: need init_val_p <= max_val_p and 1 <= max_step_p <= max_val_p");
    end

    for (genvar g = 0; g < els_p; g++) begin : g_ch
        logic [ptr_width_lp-1:0]  count_q, count_d;
        logic                     ovf_q, ovf_d;
        logic                     unf_q, unf_d;
        logic                     ovf_evt, unf_evt;
        logic [step_width_lp-1:0] up, down;
        logic [ptr_width_lp-1:0]  load_val;
        sum_t                     sum;

        assign up       = up_i[g*step_width_lp +: step_width_lp];
        assign down     = down_i[g*step_width_lp +: step_width_lp];
        assign load_val = load_val_i[g*ptr_width_lp +: ptr_width_lp];

        assign sum = sum_t'({2'b00, count_q})
                   - sum_t'({{(SumWidth - step_width_lp){1'b0}}, down})
                   + sum_t'({{(SumWidth - step_width_lp){1'b0}}, up});

        always_comb begin
            count_d = count_q;
            ovf_evt = 1'b0;
            unf_evt = 1'b0;
            if (load_v_i[g]) begin
                if (load_val > MaxVal) begin
                    count_d = MaxVal;
                    ovf_evt = 1'b1;
                end else begin
                    count_d = load_val;
                end
            end else if (sum > MaxSum) begin
                ovf_evt = 1'b1;
                count_d = (saturate_p != 0) ? MaxVal : sum[ptr_width_lp-1:0] - ModLow;
            end else if (sum[SumWidth-1]) begin
                unf_evt = 1'b1;
                count_d = (saturate_p != 0) ? '0 : sum[ptr_width_lp-1:0] + ModLow;
            end else begin
                count_d = sum[ptr_width_lp-1:0];
            end
        end

        // A fresh event outranks a clear in the same cycle.
        assign ovf_d = ovf_evt | (ovf_q & ~err_clear_i);
        assign unf_d = unf_evt | (unf_q & ~err_clear_i);

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                count_q <= InitVal;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
            end else begin
                count_q <= count_d;
                ovf_q   <= ovf_d;
                unf_q   <= unf_d;
            end
        end

        assign count_o[g*ptr_width_lp +: ptr_width_lp] = count_q;
        assign zero_o[g]      = (count_q == '0);
        assign full_o[g]      = (count_q == MaxVal);
        assign overflow_o[g]  = ovf_q;
        assign underflow_o[g] = unf_q;
    end

endmodule

// File: tb/tb_bsg_counter_up_down_multi.sv
// Directed bench: a wrapping and a saturating counter bank driven in lockstep,
// checked against hand-computed counts, status decodes and sticky flags.
module tb_bsg_counter_up_down_multi;

    localparam int unsigned Els = 4;
    localparam int unsigned Sw  = 2;
    localparam int unsigned Pw  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [Els*Sw-1:0] up, down;
    logic [Els-1:0]    load_v;
    logic [Els*Pw-1:0] load_val;
    logic              err_clear;

    logic [Els*Pw-1:0] w_count, s_count;
    logic [Els-1:0]    w_zero, w_full, w_ovf, w_unf;
    logic [Els-1:0]    s_zero, s_full, s_ovf, s_unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_counter_up_down_multi #(
        .els_p(Els), .max_val_p(9), .init_val_p(5), .max_step_p(3), .saturate_p(0)
    ) u_wrap (
        .clk_i(clk), .reset_n_i(reset_n), .up_i(up), .down_i(down),
        .load_v_i(load_v), .load_val_i(load_val), .err_clear_i(err_clear),
        .count_o(w_count), .zero_o(w_zero), .full_o(w_full),
        .overflow_o(w_ovf), .underflow_o(w_unf)
    );

    bsg_counter_up_down_multi #(
        .els_p(Els), .max_val_p(9), .init_val_p(5), .max_step_p(3), .saturate_p(1)
    ) u_sat (
        .clk_i(clk), .reset_n_i(reset_n), .up_i(up), .down_i(down),
        .load_v_i(load_v), .load_val_i(load_val), .err_clear_i(err_clear),
        .count_o(s_count), .zero_o(s_zero), .full_o(s_full),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step,
                             input logic [15:0] wc, input logic [3:0] wz, wf, wo, wu,
                             input logic [15:0] sc, input logic [3:0] sz, sf, so, su);
        check_val({step, ".w_count"}, 32'(w_count), 32'(wc));
        check_val({step, ".w_zero"},  32'(w_zero),  32'(wz));
        check_val({step, ".w_full"},  32'(w_full),  32'(wf));
        check_val({step, ".w_ovf"},   32'(w_ovf),   32'(wo));
        check_val({step, ".w_unf"},   32'(w_unf),   32'(wu));
        check_val({step, ".s_count"}, 32'(s_count), 32'(sc));
        check_val({step, ".s_zero"},  32'(s_zero),  32'(sz));
        check_val({step, ".s_full"},  32'(s_full),  32'(sf));
        check_val({step, ".s_ovf"},   32'(s_ovf),   32'(so));
        check_val({step, ".s_unf"},   32'(s_unf),   32'(su));
    endtask

    // Drive one cycle of inputs, then return to idle 1 time unit after the edge.
    task automatic apply(input logic [7:0] u, input logic [7:0] d, input logic [3:0] lv,
                         input logic [15:0] lval, input logic clr);
        up = u; down = d; load_v = lv; load_val = lval; err_clear = clr;
        @(posedge clk);
        #1;
        up = '0; down = '0; load_v = '0; load_val = '0; err_clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        up = '0; down = '0; load_v = '0; load_val = '0; err_clear = 1'b0;
        #12;
        check_all("reset", 16'h5555, 4'h0, 4'h0, 4'h0, 4'h0,
                           16'h5555, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Load ch3..ch0 = 9,4,1,9; exactly max_val is not a clamp.
        apply(8'b00_00_00_00, 8'b00_00_00_00, 4'b1111, 16'h9419, 1'b0);
        check_all("load", 16'h9419, 4'b0000, 4'b1001, 4'b0000, 4'b0000,
                          16'h9419, 4'b0000, 4'b1001, 4'b0000, 4'b0000);

        // ch0 9+1, ch1 1-3, ch2 +2-2 nets out.
        apply(8'b00_10_00_01, 8'b00_10_11_00, 4'b0000, 16'h0000, 1'b0);
        check_all("edge", 16'h9480, 4'b0001, 4'b1000, 4'b0001, 4'b0010,
                          16'h9409, 4'b0010, 4'b1001, 4'b0001, 4'b0010);

        // ch1 +3 (wraps 8 -> 1 in wrap build), ch3 -1.
        apply(8'b00_00_11_00, 8'b01_00_00_00, 4'b0000, 16'h0000, 1'b0);
        check_all("wrap_up", 16'h8410, 4'b0001, 4'b0000, 4'b0011, 4'b0010,
                             16'h8439, 4'b0000, 4'b0001, 4'b0001, 4'b0010);

        // Load beats up/down; ch3 load of 15 clamps to 9.
        apply(8'b00_01_00_00, 8'b01_00_00_00, 4'b1100, 16'hF300, 1'b0);
        check_all("ld_prio", 16'h9310, 4'b0001, 4'b1000, 4'b1011, 4'b0010,
                             16'h9339, 4'b0000, 4'b1001, 4'b1001, 4'b0010);

        apply(8'b00_00_00_00, 8'b00_00_00_00, 4'b0000, 16'h0000, 1'b1);
        check_all("clear", 16'h9310, 4'b0001, 4'b1000, 4'b0000, 4'b0000,
                           16'h9339, 4'b0000, 4'b1001, 4'b0000, 4'b0000);

        apply(8'b01_00_00_00, 8'b00_00_00_00, 4'b0000, 16'h0000, 1'b0);
        check_all("ovf3", 16'h0310, 4'b1001, 4'b0000, 4'b1000, 4'b0000,
                          16'h9339, 4'b0000, 4'b1001, 4'b1000, 4'b0000);

        // Clear together with new events: ch3 clamp load, ch0 -2.
        apply(8'b00_00_00_00, 8'b00_00_00_10, 4'b1000, 16'hF000, 1'b1);
        check_all("clr_evt", 16'h9318, 4'b0000, 4'b1000, 4'b1000, 4'b0001,
                             16'h9337, 4'b0000, 4'b1000, 4'b1000, 4'b0000);

        apply(8'b00_00_11_11, 8'b00_11_00_00, 4'b0000, 16'h0000, 1'b0);
        check_all("step3", 16'h9041, 4'b0100, 4'b1000, 4'b1001, 4'b0001,
                           16'h9069, 4'b0100, 4'b1001, 4'b1001, 4'b0000);

        // Saturating ch1 lands exactly on max: no flag.
        apply(8'b00_00_11_00, 8'b00_01_00_00, 4'b0000, 16'h0000, 1'b0);
        check_all("bound", 16'h9971, 4'b0000, 4'b1100, 4'b1001, 4'b0101,
                           16'h9099, 4'b0100, 4'b1011, 4'b1001, 4'b0100);

        // Mid-cycle asynchronous reset.
        reset_n = 1'b0;
        #2;
        check_all("async_rst", 16'h5555, 4'h0, 4'h0, 4'h0, 4'h0,
                               16'h5555, 4'h0, 4'h0, 4'h0, 4'h0);
        #1 reset_n = 1'b1;

        apply(8'b00_00_00_00, 8'b00_00_00_00, 4'b0000, 16'h0000, 1'b0);
        check_all("idle", 16'h5555, 4'h0, 4'h0, 4'h0, 4'h0,
                          16'h5555, 4'h0, 4'h0, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
